riscv_fetch_queue: RTL
======================

# riscv_fetch_queue

Parametrised instruction-fetch front end for the `riscv` pipeline core. It replaces the fixed single-cycle PC register and instruction-memory read with three things: a PC generator, a variable-latency in-order instruction-memory request/response port, and a DEPTH-entry prefetch queue. The block sits between instruction memory and the fetch/decode boundary. It absorbs decode back-pressure (stall) and discards stale fetches on a redirect from branch or jump resolution (flush).

## Interface
Parameters:
- `XLEN`, 32, PC and instruction width
- `DEPTH`, 4, prefetch queue entries and maximum in-flight requests; power of two, ≥2
- `RESET_PC`, 0, first fetch address after reset

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low (reset while `rst`=0)
- `imem_req_valid`  out  1  request to instruction memory
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  XLEN  fetch address; bits [1:0] always 0
- `imem_rsp_valid`  in  1  one in-order response this cycle
- `imem_rsp_data`  in  XLEN  instruction word
- `redirect_valid`  in  1  branch/jump taken; flush all fetch state
- `redirect_pc`  in  XLEN  new fetch address; bits [1:0] ignored
- `dec_valid`  out  1  queue head holds a valid instruction
- `dec_ready`  in  1  decode accepts head; 0 = stall
- `dec_pc`  out  XLEN  PC of head instruction
- `dec_inst`  out  XLEN  head instruction word

## Operation
- State:
  - `fetch_pc`
  - queue of DEPTH {pc, inst} entries with rd/wr pointers and `count` (0..DEPTH)
  - `inflight` (0..DEPTH): requests accepted but not yet answered
  - `drop` (0..DEPTH): responses still owed to pre-redirect requests
  - in-flight PC FIFO (DEPTH entries), tagging each response with its address
- Issue:
  - `imem_req_valid` = !`redirect_valid` && (`count` + `inflight` + `drop` < DEPTH).
  - On `imem_req_valid` && `imem_req_ready`: push `fetch_pc` to the in-flight PC FIFO, set `fetch_pc` += 4 (modulo 2^XLEN, wraps to 0), increment `inflight`.
- Response:
  - If `drop`>0: discard the response and decrement `drop`.
  - Otherwise: pop the in-flight PC FIFO, write {pc, data} to the queue, decrement `inflight`.
  - A response with `inflight`=`drop`=0 is a protocol error; it is ignored.
- Dequeue: on `dec_valid` && `dec_ready`, advance the read pointer.
- Simultaneous push and pop leaves `count` unchanged. Full queue plus a response cannot happen by construction of the credit rule.
- Redirect (highest priority) in the cycle `redirect_valid`=1:
  - `dec_valid`=0 and `imem_req_valid`=0.
  - Queue emptied; in-flight PC FIFO emptied.
  - `fetch_pc` ← {`redirect_pc`[XLEN-1:2],2'b0}.
  - `drop` ← `drop` + `inflight` − (1 if a response arrives this cycle); the arriving response is discarded.
  - `inflight` ← 0.
- Back-to-back redirects: each one reloads `fetch_pc`; `drop` accumulates.

## Timing
- Reset values:
  - `fetch_pc`=`RESET_PC`; `count`=`inflight`=`drop`=0.
  - `dec_valid`=0, `imem_req_valid`=0 while `rst`=0.
  - `dec_pc`/`dec_inst`=0 while empty.
- First `imem_req_valid`=1 in the first cycle with `rst`=1.
- Reset asserted mid-operation clears all state in that edge; later responses to earlier requests must be suppressed by the memory, because the fetch unit drops nothing after reset.
- Latency, response edge to `dec_valid` (without bypass): 1 cycle.
- Steady-state throughput: 1 instruction/cycle if memory latency < DEPTH cycles.
- Outputs `dec_*` are registered from queue storage except in the bypass case.
- Redirect to first new request: same cycle it deasserts (0 dead cycles beyond the redirect cycle).

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - Condition: `count`=0, a non-dropped response arrives, and no redirect is active.
  - In that case `dec_valid`=1 combinationally that cycle, with `dec_pc`/`dec_inst` taken from the in-flight FIFO head and `imem_rsp_data`.
  - If `dec_ready`=1 the entry is not written to the queue; otherwise it is enqueued normally.
  - Zero-cycle response-to-decode latency.
- Undefined: every response passes through the queue; 1-cycle latency; no combinational path from `imem_rsp_*` to `dec_*`.

## Test plan
- Reset, RESET_PC=0x100, memory latency 1, `dec_ready`=1 → requests 0x100,0x104,0x108…. `dec_pc` sequence 0x100,0x104,… with one instruction per cycle after fill; first `dec_valid` 2 cycles after reset release (1 with bypass).
- `dec_ready`=0 for 10 cycles, DEPTH=4 → `count`+`inflight` saturates at 4, `imem_req_valid`=0. Release → 4 queued instructions drain in order with no loss or duplication.
- Memory latency 3, redirect to 0x2002 with 2 requests in flight → `drop`=2; both stale responses discarded; next `imem_req_addr`=0x2000; first `dec_pc`=0x2000.
- Redirect in the same cycle as a response and a `dec_ready` handshake → response dropped, `dec_valid`=0 that cycle, `drop` = `inflight`−1.
- `fetch_pc`=0xFFFFFFFC issued → next `imem_req_addr`=0x00000000.
- `imem_req_ready` random 50% with latency 1–3 cycles → decode stream identical to a golden sequential PC model across 1000 instructions.

Source files
------------

// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_queue
// Brief    : PC generator, in-order variable-latency imem port and DEPTH-entry
//            prefetch queue; optional response bypass via FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module riscv_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_inst
);

   localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cw = c_pw + 1;
   localparam int c_sw = c_cw + 2;
   localparam logic [c_sw-1:0] c_depth = c_sw'(DEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_q_pc   [DEPTH];
   logic [XLEN-1:0] r_q_inst [DEPTH];
   logic [c_pw-1:0] r_q_rd;
   logic [c_pw-1:0] r_q_wr;
   logic [c_cw-1:0] r_count;
   logic [c_cw-1:0] r_inflight;
   logic [c_cw-1:0] r_drop;
   logic [XLEN-1:0] r_if_pc  [DEPTH];
   logic [c_pw-1:0] r_if_rd;
   logic [c_pw-1:0] r_if_wr;

   logic [c_sw-1:0] w_credit_sum;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_rsp_take;
   logic            w_rsp_drop;
   logic            w_rsp_any;
   logic [c_cw-1:0] w_drop_redir;
   logic            w_q_valid;
   logic            w_q_pop;
   logic            w_enq;
   logic            w_bypass;
   logic [XLEN-1:0] w_if_head_pc;
   logic [XLEN-1:0] w_q_head_pc;
   logic [XLEN-1:0] w_q_head_inst;
   logic            w_unused;

   // Credit rule: queue slots, outstanding and still-owed responses never exceed DEPTH.
   assign w_credit_sum = c_sw'(r_count) + c_sw'(r_inflight) + c_sw'(r_drop);
   assign w_req_valid  = rst && !redirect_valid && (w_credit_sum < c_depth);
   assign w_req_fire   = w_req_valid && imem_req_ready;

   assign w_rsp_drop   = imem_rsp_valid && (r_drop != '0);
   assign w_rsp_take   = rst && !redirect_valid && imem_rsp_valid &&
                         (r_drop == '0) && (r_inflight != '0);
   assign w_rsp_any    = imem_rsp_valid && ((r_drop != '0) || (r_inflight != '0));
   assign w_drop_redir = r_drop + r_inflight - c_cw'(w_rsp_any);

   assign w_if_head_pc  = r_if_pc[r_if_rd];
   assign w_q_valid     = rst && !redirect_valid && (r_count != '0);
   assign w_q_head_pc   = (r_count != '0) ? r_q_pc[r_q_rd]   : '0;
   assign w_q_head_inst = (r_count != '0) ? r_q_inst[r_q_rd] : '0;
   assign w_q_pop       = w_q_valid && dec_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue: the arriving response is presented to decode in its own cycle.
   assign w_bypass  = w_rsp_take && (r_count == '0);
   assign dec_valid = w_q_valid || w_bypass;
   assign dec_pc    = w_bypass ? w_if_head_pc  : w_q_head_pc;
   assign dec_inst  = w_bypass ? imem_rsp_data : w_q_head_inst;
   assign w_enq     = w_rsp_take && !(w_bypass && dec_ready);
`else
   assign w_bypass  = 1'b0;
   assign dec_valid = w_q_valid;
   assign dec_pc    = w_q_head_pc;
   assign dec_inst  = w_q_head_inst;
   assign w_enq     = w_rsp_take;
`endif

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign w_unused       = ^{redirect_pc[1:0], w_bypass};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
         r_q_rd     <= '0;
         r_q_wr     <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
         r_if_rd    <= '0;
         r_if_wr    <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         r_q_rd     <= '0;
         r_q_wr     <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= w_drop_redir;
         r_if_rd    <= '0;
         r_if_wr    <= '0;
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
            r_if_wr    <= r_if_wr + c_pw'(1);
         end
         if (w_rsp_take) begin
            r_if_rd <= r_if_rd + c_pw'(1);
         end
         if (w_rsp_drop) begin
            r_drop <= r_drop - c_cw'(1);
         end
         r_inflight <= r_inflight + c_cw'(w_req_fire) - c_cw'(w_rsp_take);
         if (w_enq) begin
            r_q_wr <= r_q_wr + c_pw'(1);
         end
         if (w_q_pop) begin
            r_q_rd <= r_q_rd + c_pw'(1);
         end
         r_count <= r_count + c_cw'(w_enq) - c_cw'(w_q_pop);
      end
   end

   // Storage arrays carry no reset; validity is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_if_pc[r_if_wr] <= r_fetch_pc;
      end
      if (w_enq) begin
         r_q_pc[r_q_wr]   <= w_if_head_pc;
         r_q_inst[r_q_wr] <= imem_rsp_data;
      end
   end

endmodule
`default_nettype wire
